// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the score display's 7-segment digit encoding.
//
// Segment bit order inside a 7-bit glyph is {g,f,e,d,c,b,a}, so bit 0 is
// segment 'a'. Glyphs are active-low, which means a 0 bit lights a segment.
//
// Contents:
//    SEG7_GLYPH[0:9]   active-low glyphs for the decimal digits
//    SEG7_BLANK        all segments dark
//    SEG7_ERR          error glyph (segments a, d and g lit)
//    seg7_dec_state_e  reader FSM states
//    seg7_idx_width()  index width helper that never returns zero
// -----------------------------------------------------------------------------
package seg7_pkg;

   // Active-low glyphs for digits 0 through 9, in {g,f,e,d,c,b,a} order.
   localparam logic [6:0] SEG7_GLYPH [0:9] = '{
      7'h40,   // 0
      7'h79,   // 1
      7'h24,   // 2
      7'h30,   // 3
      7'h19,   // 4
      7'h12,   // 5
      7'h02,   // 6
      7'h78,   // 7
      7'h00,   // 8
      7'h10    // 9
   };

   // A dark digit counts as a leading zero, not as an error.
   localparam logic [6:0] SEG7_BLANK = 7'h7F;

   // The display driver shows this glyph for digits it cannot represent.
   localparam logic [6:0] SEG7_ERR = 7'b0110110;

   typedef enum logic [1:0] {
      WAIT    = 2'd0,
      CONV    = 2'd1,
      PRESENT = 2'd2
   } seg7_dec_state_e;

   // Width of a counter that indexes n items. It is at least one bit,
   // so a single-digit build still gets a legal vector.
   function automatic int seg7_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational decoder that maps one active-low 7-segment glyph back to BCD.
//
// Ports:
//    glyph_i    in   7   active-low glyph, {g,f,e,d,c,b,a}
//    digit_o    out  4   decoded digit, or 0 for blank or invalid glyphs
//    invalid_o  out  1   high when the glyph is neither 0-9 nor blank
//
// The error glyph needs no special case. It matches no digit and is not
// blank, so it falls through to the invalid path like any other pattern.
// -----------------------------------------------------------------------------
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] glyph_i,
   output logic [3:0] digit_o,
   output logic       invalid_o
);

   // Start by assuming an unknown glyph: it decodes to 0 and is invalid
   // unless it is blank. A match against the digit table clears the flag.
   always_comb begin
      digit_o   = 4'd0;
      invalid_o = (glyph_i != SEG7_BLANK);
      for (int i = 0; i < 10; i++) begin
         if (glyph_i == SEG7_GLYPH[i]) begin
            digit_o   = 4'(i);
            invalid_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_score_decoder.sv
// -----------------------------------------------------------------------------
// seg7_score_decoder
// Reader side of the score display. It watches the bank of active-low
// 7-segment buses and waits until the bank has held steady. It then decodes
// each digit back to BCD, folds the digits most-significant first into a
// binary score, and offers the result on a valid/ready port.
//
// Parameters:
//    NUM_DIGITS     number of digits on seg_bus; digit 0 is least significant
//    STABLE_CYCLES  unchanged samples required before a capture (>= 1)
//    SCORE_W        derived width that holds 10**NUM_DIGITS-1
//
// Ports:
//    Clk        in   1             rising-edge clock
//    Reset_n    in   1             asynchronous active-low reset
//    seg_bus    in   7*NUM_DIGITS  digit i at [7*i+6:7*i], active-low
//    out_ready  in   1             consumer takes the result when high
//    out_valid  out  1             result offered, held stable while high
//    out_score  out  SCORE_W       binary score
//    out_bcd    out  4*NUM_DIGITS  decoded digits, digit i at [4*i+3:4*i]
//    out_err    out  1             capture held a glyph other than 0-9/blank
//
// Optional feature:
//    SEG7_DEC_CHANGE_ONLY_EN - when defined, a capture whose {score,err}
//    matches the last presented result is dropped instead of presented.
//    The first capture after reset is always presented.
// -----------------------------------------------------------------------------
module seg7_score_decoder
   import seg7_pkg::*;
#(
   parameter  int NUM_DIGITS    = 3,
   parameter  int STABLE_CYCLES = 4,
   localparam int SCORE_W       = $clog2(10 ** NUM_DIGITS)
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic [7*NUM_DIGITS-1:0] seg_bus,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [SCORE_W-1:0]      out_score,
   output logic [4*NUM_DIGITS-1:0] out_bcd,
   output logic                    out_err
);

   localparam int                IDX_W    = seg7_idx_width(NUM_DIGITS);
   localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);

   seg7_dec_state_e                 state_q,    state_d;
   logic [7*NUM_DIGITS-1:0]         seg_q;
   logic [CNT_W-1:0]                stabCnt_q,  stabCnt_d;
   logic [NUM_DIGITS-1:0][6:0]      snap_q,     snap_d;
   logic [SCORE_W-1:0]              acc_q,      acc_d;
   logic [IDX_W-1:0]                digIdx_q,   digIdx_d;
   logic                            errAcc_q,   errAcc_d;
   logic                            valid_q,    valid_d;
   logic [SCORE_W-1:0]              score_q,    score_d;
   logic [NUM_DIGITS-1:0][3:0]      bcd_q,      bcd_d;
   logic                            err_q,      err_d;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
   logic                            lastVld_q,  lastVld_d;
`endif

   logic [6:0]                      curGlyph;
   logic [3:0]                      curDigit;
   logic                            curInvalid;
   logic [SCORE_W-1:0]              accNext;
   logic                            errNext;

   // One decoder serves every digit. The snapshot is walked one digit per
   // cycle, so dig_idx chooses which glyph reaches the decoder.
   assign curGlyph = snap_q[digIdx_q];

   seg7_glyph_decode uGlyphDecode (
      .glyph_i   (curGlyph),
      .digit_o   (curDigit),
      .invalid_o (curInvalid)
   );

   // Next values while converting. acc*10 + d cannot overflow, because
   // SCORE_W is sized to hold the largest NUM_DIGITS-digit number.
   assign accNext = SCORE_W'(acc_q * SCORE_W'(10)) + SCORE_W'(curDigit);
   assign errNext = errAcc_q | curInvalid;

   // Next-state logic for the reader FSM. Every register holds its value
   // unless a state below says otherwise.
   always_comb begin
      state_d   = state_q;
      stabCnt_d = stabCnt_q;
      snap_d    = snap_q;
      acc_d     = acc_q;
      digIdx_d  = digIdx_q;
      errAcc_d  = errAcc_q;
      valid_d   = valid_q;
      score_d   = score_q;
      bcd_d     = bcd_q;
      err_d     = err_q;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
      lastVld_d = lastVld_q;
`endif

      unique case (state_q)
         WAIT: begin
            // Stability is measured only here. Any difference between
            // the live bus and the previous sample restarts the count.
            if (seg_bus != seg_q) begin
               stabCnt_d = '0;
            end else if (stabCnt_q != CNT_MAX) begin
               stabCnt_d = stabCnt_q + CNT_W'(1);
            end

            if (stabCnt_q == CNT_MAX) begin
               snap_d    = seg_q;
               acc_d     = '0;
               digIdx_d  = LAST_IDX;
               errAcc_d  = 1'b0;
               stabCnt_d = '0;
               state_d   = CONV;
            end
         end

         CONV: begin
            acc_d           = accNext;
            errAcc_d        = errNext;
            bcd_d[digIdx_q] = curDigit;

            if (digIdx_q == '0) begin
`ifdef SEG7_DEC_CHANGE_ONLY_EN
               // score_q and err_q still hold the last presented result,
               // so a repeat of that result is dropped here.
               if (lastVld_q && (accNext == score_q) && (errNext == err_q)) begin
                  state_d = WAIT;
               end else begin
                  score_d   = accNext;
                  err_d     = errNext;
                  valid_d   = 1'b1;
                  lastVld_d = 1'b1;
                  state_d   = PRESENT;
               end
`else
               score_d = accNext;
               err_d   = errNext;
               valid_d = 1'b1;
               state_d = PRESENT;
`endif
            end else begin
               digIdx_d = digIdx_q - IDX_W'(1);
            end
         end

         PRESENT: begin
            // The result stays frozen until the consumer accepts it.
            if (out_ready) begin
               valid_d   = 1'b0;
               stabCnt_d = '0;
               state_d   = WAIT;
            end
         end

         default: begin
            state_d = WAIT;
         end
      endcase
   end

   // Input sampler. It runs every cycle whatever the FSM state, so it is
   // already current when the FSM returns to WAIT.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         seg_q <= {NUM_DIGITS{SEG7_BLANK}};
      end else begin
         seg_q <= seg_bus;
      end
   end

   // FSM and datapath registers. Reset discards any partial conversion
   // and any result still on offer.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= WAIT;
         stabCnt_q <= '0;
         snap_q    <= {NUM_DIGITS{SEG7_BLANK}};
         acc_q     <= '0;
         digIdx_q  <= LAST_IDX;
         errAcc_q  <= 1'b0;
         valid_q   <= 1'b0;
         score_q   <= '0;
         bcd_q     <= '0;
         err_q     <= 1'b0;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
         lastVld_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         stabCnt_q <= stabCnt_d;
         snap_q    <= snap_d;
         acc_q     <= acc_d;
         digIdx_q  <= digIdx_d;
         errAcc_q  <= errAcc_d;
         valid_q   <= valid_d;
         score_q   <= score_d;
         bcd_q     <= bcd_d;
         err_q     <= err_d;
`ifdef SEG7_DEC_CHANGE_ONLY_EN
         lastVld_q <= lastVld_d;
`endif
      end
   end

   assign out_valid = valid_q;
   assign out_score = score_q;
   assign out_bcd   = bcd_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_seg7_score_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_score_decoder
// Directed bench for seg7_score_decoder with NUM_DIGITS=3 and
// STABLE_CYCLES=4. It keeps its own copy of the glyph table. The expected
// scores, BCD values and capture latencies are worked out by hand.
// -----------------------------------------------------------------------------
module tb_seg7_score_decoder;

   localparam int NUM_DIGITS    = 3;
   localparam int STABLE_CYCLES = 4;

   logic        Clk;
   logic        Reset_n;
   logic [20:0] seg_bus;
   logic        out_ready;
   logic        out_valid;
   logic [9:0]  out_score;
   logic [11:0] out_bcd;
   logic        out_err;

   int checks;
   int errors;

   logic [6:0] glyph [10];
   localparam logic [6:0] BLANK = 7'h7F;
   localparam logic [6:0] ERRG  = 7'b0110110;

   seg7_score_decoder #(
      .NUM_DIGITS    (NUM_DIGITS),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .seg_bus   (seg_bus),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_score (out_score),
      .out_bcd   (out_bcd),
      .out_err   (out_err)
   );

   // Free-running clock with a 10 ns period.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Packs three glyphs into a bus, most significant digit first.
   function automatic logic [20:0] mk(input logic [6:0] d2, input logic [6:0] d1,
                                      input logic [6:0] d0);
      return {d2, d1, d0};
   endfunction

   // Resets the DUT while the new bus value is driven, then releases reset
   // on a falling edge. The next rising edge is the first one that loads
   // the value (E0).
   task automatic applyStimulus(input logic [20:0] bus);
      @(negedge Clk);
      Reset_n = 1'b0;
      seg_bus = bus;
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   // Counts rising edges until out_valid is seen high 1 ns after an edge.
   // The first edge counts as 0. Returns -1 if the budget runs out.
   task automatic waitValid(input int budget, output int cycles);
      cycles = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clk);
         #1;
         if (out_valid === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   // Checks the reset values, both from power-up and from a mid-run reset
   // while a result is on offer.
   task automatic test_reset;
      int k;
      Reset_n   = 1'b0;
      seg_bus   = {3{BLANK}};
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_score !== 10'd0) begin
         errors++;
         $display("[TB] FAIL reset_score: got %0d expected 0", out_score);
      end
      checks++;
      if (out_bcd !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_bcd: got %h expected 000", out_bcd);
      end
      checks++;
      if (out_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_err: got %b expected 0", out_err);
      end

      out_ready = 1'b0;
      applyStimulus(mk(glyph[1], glyph[2], glyph[3]));
      waitValid(30, k);
      checks++;
      if (k != 8) begin
         errors++;
         $display("[TB] FAIL midrun_setup_latency: got %0d expected 8", k);
      end
      Reset_n = 1'b0;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_score !== 10'd0 || out_err !== 1'b0 || out_bcd !== 12'h000) begin
         errors++;
         $display("[TB] FAIL midrun_reset: got valid=%b score=%0d err=%b bcd=%h expected 0/0/0/000",
                  out_valid, out_score, out_err, out_bcd);
      end
      out_ready = 1'b1;
   endtask

   // Digits "123" on a steady bus. Checks the capture latency, the decoded
   // values, the drop of out_valid after the handshake, and the periodic
   // re-report (only in the default build).
   task automatic test_static_123;
      int k;
      out_ready = 1'b1;
      applyStimulus(mk(glyph[1], glyph[2], glyph[3]));
      waitValid(30, k);
      checks++;
      if (k != 8) begin
         errors++;
         $display("[TB] FAIL static_latency: got %0d expected 8", k);
      end
      checks++;
      if (out_score !== 10'd123) begin
         errors++;
         $display("[TB] FAIL static_score: got %0d expected 123", out_score);
      end
      checks++;
      if (out_bcd !== 12'h123) begin
         errors++;
         $display("[TB] FAIL static_bcd: got %h expected 123", out_bcd);
      end
      checks++;
      if (out_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL static_err: got %b expected 0", out_err);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL static_drop: got %b expected 0", out_valid);
      end
`ifndef SEG7_DEC_CHANGE_ONLY_EN
      // The period is 9 cycles. One of them was used by the drop check,
      // so the next pulse is 8 edges later (index 7).
      waitValid(30, k);
      checks++;
      if (k != 7 || out_score !== 10'd123) begin
         errors++;
         $display("[TB] FAIL rereport: got k=%0d score=%0d expected k=7 score=123", k, out_score);
      end
`endif
   endtask

   // Toggles the bus every 3 cycles, which is never long enough to capture.
   // When the toggling stops, exactly one capture follows at E0+8.
   task automatic test_toggle;
      int   k;
      logic sawValid;
      logic [20:0] busA;
      logic [20:0] busB;
      logic [20:0] busF;
      busA = mk(glyph[1], glyph[2], glyph[3]);
      busB = mk(glyph[8], glyph[8], glyph[8]);
      busF = mk(glyph[4], glyph[5], glyph[6]);
      sawValid  = 1'b0;
      out_ready = 1'b1;
      applyStimulus(busA);
      for (int t = 0; t < 10; t++) begin
         repeat (3) begin
            @(posedge Clk);
            #1;
            if (out_valid === 1'b1) sawValid = 1'b1;
         end
         @(negedge Clk);
         if (t == 9) seg_bus = busF;
         else        seg_bus = (t % 2 == 0) ? busB : busA;
      end
      checks++;
      if (sawValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL toggle_no_valid: got %b expected 0", sawValid);
      end
      waitValid(30, k);
      checks++;
      if (k != 8 || out_score !== 10'd456) begin
         errors++;
         $display("[TB] FAIL toggle_capture: got k=%0d score=%0d expected k=8 score=456", k, out_score);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL toggle_single: got %b expected 0", out_valid);
      end
   endtask

   // An error glyph in the middle digit, then a blank leading digit.
   task automatic test_err_blank;
      int k;
      out_ready = 1'b1;
      applyStimulus(mk(glyph[0], ERRG, glyph[7]));
      waitValid(30, k);
      checks++;
      if (k != 8 || out_score !== 10'd7 || out_bcd !== 12'h007 || out_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_glyph: got k=%0d score=%0d bcd=%h err=%b expected 8/7/007/1",
                  k, out_score, out_bcd, out_err);
      end
      applyStimulus(mk(BLANK, glyph[4], glyph[2]));
      waitValid(30, k);
      checks++;
      if (k != 8 || out_score !== 10'd42 || out_bcd !== 12'h042 || out_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL blank_msd: got k=%0d score=%0d bcd=%h err=%b expected 8/42/042/0",
                  k, out_score, out_bcd, out_err);
      end
   endtask

   // Holds out_ready low for 20 cycles while the bus changes. The result
   // must stay frozen. After the handshake, the new value is reported
   // 8 edges later.
   task automatic test_backpressure;
      int k;
      out_ready = 1'b0;
      applyStimulus(mk(glyph[1], glyph[2], glyph[3]));
      waitValid(30, k);
      checks++;
      if (k != 8) begin
         errors++;
         $display("[TB] FAIL bp_latency: got %0d expected 8", k);
      end
      @(negedge Clk);
      seg_bus = mk(glyph[9], glyph[9], glyph[9]);
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_score !== 10'd123 || out_bcd !== 12'h123 || out_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle %0d: got valid=%b score=%0d bcd=%h expected 1/123/123",
                     c, out_valid, out_score, out_bcd);
         end
      end
      @(negedge Clk);
      out_ready = 1'b1;
      @(posedge Clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_accept: got %b expected 0", out_valid);
      end
      waitValid(30, k);
      checks++;
      if (k != 7 || out_score !== 10'd999 || out_bcd !== 12'h999) begin
         errors++;
         $display("[TB] FAIL bp_new: got k=%0d score=%0d bcd=%h expected 7/999/999", k, out_score, out_bcd);
      end
   endtask

`ifdef SEG7_DEC_CHANGE_ONLY_EN
   // A constant "555" is reported once. Changing to "556" reports again.
   task automatic test_change_only;
      int k;
      int pulses;
      pulses    = 0;
      out_ready = 1'b1;
      applyStimulus(mk(glyph[5], glyph[5], glyph[5]));
      for (int c = 0; c < 200; c++) begin
         @(posedge Clk);
         #1;
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("[TB] FAIL change_only_pulses: got %0d expected 1", pulses);
      end
      @(negedge Clk);
      seg_bus = mk(glyph[5], glyph[5], glyph[6]);
      waitValid(40, k);
      checks++;
      if (k < 0 || out_score !== 10'd556) begin
         errors++;
         $display("[TB] FAIL change_only_new: got k=%0d score=%0d expected found/556", k, out_score);
      end
   endtask
`endif

   // Runs the scenarios in order and prints the summary line.
   initial begin
      checks = 0;
      errors = 0;
      glyph  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      test_reset();
      test_static_123();
      test_toggle();
      test_err_blank();
      test_backpressure();
`ifdef SEG7_DEC_CHANGE_ONLY_EN
      test_change_only();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
